frame_swap_scheduler: RTL
=========================

# frame_swap_scheduler

Sequences the display-domain frame-buffer rotation. It converts camera-writer end-of-frame pulses into the write-done strobe for the frame pointer controller. It issues the frame-swap toggle on a display vsync boundary once a new frame is available, then launches and supervises the processing/overlay-draw pass on the newly selected frame. It sits in the `disp_clk_i` domain between the camera write DMA, the display timing generator, the processing engine and the frame pointer controller.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 24'd10_000_000: maximum cycles spent in WAIT_PROC before forced abort; legal range 2..2^24-1.

Ports:
- `disp_clk_i` input 1: display clock; the single clock of the block.
- `resetn_i` input 1: asynchronous, active-low reset.
- `d_enable_i` input 1: level; when low, no new swap is started.
- `d_cam_frame_end_i` input 1: one-cycle pulse, camera writer finished a frame.
- `d_vsync_i` input 1: display vsync level, already synchronous to `disp_clk_i`.
- `d_proc_done_i` input 1: one-cycle pulse, processing pass complete.
- `d_frame_wr_done_o` output 1: one-cycle pulse to the pointer controller.
- `d_frame_swap_toggle_o` output 1: level that toggles once per swap.
- `d_proc_start_o` output 1: one-cycle pulse, start processing the new frame.
- `d_busy_o` output 1: high in every state except WAIT_FRAME.
- `d_swap_cnt_o` output 16: swaps issued, saturating.
- `d_drop_cnt_o` output 16: camera frames overwritten before use, saturating.
- `d_timeout_cnt_o` output 16: processing timeouts, saturating.

## Operation
- `d_frame_wr_done_o` is `d_cam_frame_end_i` registered once; it is unconditional and independent of FSM state.
- `pending` flag:
  - Set by `d_cam_frame_end_i`.
  - Cleared when a swap is issued.
  - If set and clear occur in the same cycle, set wins and no drop is counted.
  - If `d_cam_frame_end_i` arrives while `pending` is already 1 and no swap occurs that cycle, `d_drop_cnt_o` increments.
- Vsync rise detection: `vs_q` holds `d_vsync_i` delayed one cycle; `rise = d_vsync_i & ~vs_q`.
- FSM states (package enum): WAIT_FRAME, SETTLE, START, WAIT_PROC.
  - WAIT_FRAME: when `rise & pending & d_enable_i`, toggle `d_frame_swap_toggle_o`, clear `pending`, increment `d_swap_cnt_o`, and go to SETTLE. Otherwise stay.
  - SETTLE: one cycle so the pointer controller's new process address is stable. Go to START.
  - START: assert `d_proc_start_o` for one cycle, clear the timeout counter, and go to WAIT_PROC.
  - WAIT_PROC: on `d_proc_done_i`, go to WAIT_FRAME. Otherwise, when the timeout counter reaches `TIMEOUT_CYCLES-1`, increment `d_timeout_cnt_o` and go to WAIT_FRAME. Otherwise increment the timeout counter.
- Boundary conditions:
  - `d_proc_done_i` and timeout in the same cycle: done wins, no timeout counted.
  - `d_proc_done_i` outside WAIT_PROC: ignored.
  - A vsync rise outside WAIT_FRAME is ignored; the swap waits for the next rise.
  - Deasserting `d_enable_i` mid-pass does not abort; it only blocks the next swap.
- All counters saturate at 16'hFFFF and never wrap.
- Reset mid-operation: immediate return to reset values. An in-flight processing pass is abandoned and no done is expected.

## Timing
- Reset values:
  - All outputs 0: toggle, `d_frame_wr_done_o`, `d_proc_start_o`, `d_busy_o`, all counters.
  - Internal: state WAIT_FRAME, `pending` 0, `vs_q` 0.
- `d_frame_wr_done_o`: 1-cycle latency from `d_cam_frame_end_i`.
- Cycle N is the first cycle `d_vsync_i`=1 (rise) with `pending`=1 and `d_enable_i`=1:
  - Toggle changes at N+1.
  - `d_busy_o` goes high at N+1.
  - `d_proc_start_o` is high during cycle N+3 only.
- Done latency: `d_proc_done_i` in cycle M returns the FSM to WAIT_FRAME at M+1, and `d_busy_o` drops at M+1.
- Earliest next swap: the first rise after M+1.
- All outputs are driven directly from flops.

## Structure
- Package `frame_sched_pkg`: state enum `sched_state_e`, `STAT_W = 16`, `TIMEOUT_W = 24`.
- One sub-module, `sat_counter`: parameterised width, synchronous increment, saturating, asynchronous active-low reset. It is instantiated three times.
- FSM, pending logic and vsync edge detection live in the top module.

## Test plan
- Reset, then one `d_cam_frame_end_i` pulse, then a vsync rise:
  - `d_frame_wr_done_o` pulses 1 cycle after the camera pulse.
  - Toggle goes 0→1 one cycle after the rise.
  - `d_proc_start_o` pulses 3 cycles after the rise.
  - `d_swap_cnt_o`=1.
- Three camera pulses with no vsync: `d_drop_cnt_o`=2 and `pending`=1. A subsequent rise gives exactly one swap.
- `TIMEOUT_CYCLES`=8 with `d_proc_done_i` never asserted: `d_timeout_cnt_o`=1 and `d_busy_o` drops 8 cycles after `d_proc_start_o`. A late `d_proc_done_i` is then ignored.
- Simultaneous events:
  - `d_proc_done_i` in the timeout cycle: `d_timeout_cnt_o` stays 0.
  - Camera pulse in the swap cycle: `pending`=1 afterwards and `d_drop_cnt_o` is unchanged.
- `d_enable_i`=0 with `pending`=1 across 4 vsync rises: no toggle. Raising enable gives a swap on the next rise.
- `resetn_i` pulsed low during WAIT_PROC: all outputs 0 asynchronously, and the FSM resumes in WAIT_FRAME.
- Saturation, with counters forced near the limit: 70000 drops yields `d_drop_cnt_o`=16'hFFFF.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and widths for the display-domain frame swap scheduler.
package frame_sched_pkg;

  localparam int STAT_W    = 16;
  localparam int TIMEOUT_W = 24;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    SETTLE,
    START,
    WAIT_PROC
  } sched_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/frame_swap_scheduler.sv
// Turns camera end-of-frame pulses into vsync-aligned buffer swaps and
// launches/supervises the processing pass on each newly selected frame.
module frame_swap_scheduler
  import frame_sched_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              disp_clk_i,
  input  logic              resetn_i,
  input  logic              d_enable_i,
  input  logic              d_cam_frame_end_i,
  input  logic              d_vsync_i,
  input  logic              d_proc_done_i,
  output logic              d_frame_wr_done_o,
  output logic              d_frame_swap_toggle_o,
  output logic              d_proc_start_o,
  output logic              d_busy_o,
  output logic [STAT_W-1:0] d_swap_cnt_o,
  output logic [STAT_W-1:0] d_drop_cnt_o,
  output logic [STAT_W-1:0] d_timeout_cnt_o
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  sched_state_e         state_q;
  logic                 vs_q;
  logic                 pending_q;
  logic                 pending_d;
  logic                 wr_done_q;
  logic                 toggle_q;
  logic                 start_q;
  logic                 busy_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_q;

  logic rise;
  logic swap;
  logic proc_done;
  logic timeout_hit;
  logic drop;

  assign rise        = d_vsync_i & ~vs_q;
  assign swap        = (state_q == WAIT_FRAME) & rise & pending_q & d_enable_i;
  assign proc_done   = (state_q == WAIT_PROC) & d_proc_done_i;
  assign timeout_hit = (state_q == WAIT_PROC) & ~d_proc_done_i & (tmo_cnt_q == TMO_LAST);
  // A new frame landing in the swap cycle replaces the one being consumed, so it is not a drop.
  assign drop        = d_cam_frame_end_i & pending_q & ~swap;
  assign pending_d   = d_cam_frame_end_i | (pending_q & ~swap);

  always_ff @(posedge disp_clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= WAIT_FRAME;
      vs_q      <= 1'b0;
      pending_q <= 1'b0;
      wr_done_q <= 1'b0;
      toggle_q  <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      vs_q      <= d_vsync_i;
      wr_done_q <= d_cam_frame_end_i;
      pending_q <= pending_d;
      start_q   <= 1'b0;
      case (state_q)
        WAIT_FRAME: begin
          if (swap) begin
            toggle_q <= ~toggle_q;
            busy_q   <= 1'b1;
            state_q  <= SETTLE;
          end
        end
        SETTLE: begin
          state_q <= START;
        end
        START: begin
          start_q   <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= WAIT_PROC;
        end
        WAIT_PROC: begin
          if (proc_done || timeout_hit) begin
            busy_q  <= 1'b0;
            state_q <= WAIT_FRAME;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TIMEOUT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= WAIT_FRAME;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(STAT_W)) u_swap_cnt (
    .clk_i   (disp_clk_i),
    .rst_ni  (resetn_i),
    .inc_i   (swap),
    .count_o (d_swap_cnt_o)
  );

  sat_counter #(.WIDTH(STAT_W)) u_drop_cnt (
    .clk_i   (disp_clk_i),
    .rst_ni  (resetn_i),
    .inc_i   (drop),
    .count_o (d_drop_cnt_o)
  );

  sat_counter #(.WIDTH(STAT_W)) u_timeout_cnt (
    .clk_i   (disp_clk_i),
    .rst_ni  (resetn_i),
    .inc_i   (timeout_hit),
    .count_o (d_timeout_cnt_o)
  );

  assign d_frame_wr_done_o     = wr_done_q;
  assign d_frame_swap_toggle_o = toggle_q;
  assign d_proc_start_o        = start_q;
  assign d_busy_o              = busy_q;

endmodule
